// File: rtl/layer_out_serializer.sv
// Layer output serializer.
// Accepts a whole layer's parallel neuron outputs as one frame and streams the
// words out one per cycle, neuron 0 first, to the next layer's serial input.
// A one-deep pending buffer lets a second frame arrive while the first is still
// being sent; the pending frame follows the active one with no idle cycle.
// A frame that arrives while both buffers are occupied is dropped and flagged
// on the sticky overrun output.
module layer_out_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [numNeurons*dataWidth-1:0]  in_data,
    input  logic                             in_valid,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    output logic                             out_last,
    output logic                             busy,
    output logic                             overrun
);

    localparam int FRAME_W = numNeurons * dataWidth;
    localparam int IDX_W   = (numNeurons > 1) ? $clog2(numNeurons) : 1;

    localparam logic [IDX_W-1:0] FIRST_IDX = '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(numNeurons - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q,     state_d;
    logic [IDX_W-1:0]     idx_q,       idx_d;
    logic [FRAME_W-1:0]   active_q,    active_d;
    logic [FRAME_W-1:0]   pend_q,      pend_d;
    logic                 pend_full_q, pend_full_d;
    logic [dataWidth-1:0] out_data_q,  out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q,  out_last_d;
    logic                 overrun_q,   overrun_d;

    // Word i of a frame; neuron k lives at bits [k*dataWidth +: dataWidth].
    function automatic logic [dataWidth-1:0] word_at(
        input logic [FRAME_W-1:0] frame,
        input logic [IDX_W-1:0]   i
    );
        return frame[int'(i) * dataWidth +: dataWidth];
    endfunction

    // idx_q always names the word currently shown on out_data while in SEND,
    // so the first word is registered on the same edge that captures a frame.
    // Next-state, buffer and output-register logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        overrun_d   = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    active_d    = in_data;
                    idx_d       = FIRST_IDX;
                    state_d     = SEND;
                    out_valid_d = 1'b1;
                    out_data_d  = word_at(in_data, FIRST_IDX);
                    out_last_d  = (FIRST_IDX == LAST_IDX);
                end
            end

            SEND: begin
                if (idx_q != LAST_IDX) begin
                    // Mid-frame: advance to the next word of the active frame.
                    idx_d       = idx_q + IDX_W'(1);
                    out_valid_d = 1'b1;
                    out_data_d  = word_at(active_q, idx_d);
                    out_last_d  = (idx_d == LAST_IDX);
                    if (in_valid) begin
                        if (!pend_full_q) begin
                            pend_d      = in_data;
                            pend_full_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (pend_full_q) begin
                    // Last word going out and a frame is waiting: promote it
                    // so its first word follows without a gap. A frame
                    // arriving now refills the slot just vacated.
                    active_d    = pend_q;
                    idx_d       = FIRST_IDX;
                    out_valid_d = 1'b1;
                    out_data_d  = word_at(pend_q, FIRST_IDX);
                    out_last_d  = (FIRST_IDX == LAST_IDX);
                    if (in_valid) begin
                        pend_d = in_data;
                    end else begin
                        pend_full_d = 1'b0;
                    end
                end else if (in_valid) begin
                    // Last word going out, nothing pending, but a new frame
                    // arrives: start it directly rather than idling a cycle.
                    active_d    = in_data;
                    idx_d       = FIRST_IDX;
                    out_valid_d = 1'b1;
                    out_data_d  = word_at(in_data, FIRST_IDX);
                    out_last_d  = (FIRST_IDX == LAST_IDX);
                end else begin
                    state_d = IDLE;
                    idx_d   = FIRST_IDX;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any frame in flight and
    // discards the pending frame by clearing its full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pend_full_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_full_q <= pend_full_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overrun_q   <= overrun_d;
        end
    end

    // Frame buffers carry data only; their contents are meaningless after
    // reset because the state and full flag say nothing is held.
    always_ff @(posedge clk) begin
        active_q <= active_d;
        pend_q   <= pend_d;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == SEND) || pend_full_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Testbench for layer_out_serializer (numNeurons=4, dataWidth=16).
// A word-queue model tracks every word still owed to the output; a frame is
// accepted when at most one frame's worth of words is still owed after the
// word being shown, otherwise it is dropped.
module tb_layer_out_serializer;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int FW = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_data = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    layer_out_serializer #(
        .numNeurons(N),
        .dataWidth (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .busy     (busy),
        .overrun  (overrun)
    );

    // Model state: queue of {last, data} words not yet shown.
    logic [W:0]   sched[$];
    logic         m_valid = 1'b0;
    logic         m_last  = 1'b0;
    logic         m_busy  = 1'b0;
    logic         m_ovr   = 1'b0;
    logic [W-1:0] m_data  = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [W:0] w;
        if (rst) begin
            sched.delete();
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_data  = '0;
            m_ovr   = 1'b0;
        end else begin
            if (in_valid) begin
                if (sched.size() <= N) begin
                    for (int k = 0; k < N; k++)
                        sched.push_back({(k == N - 1), in_data[k*W +: W]});
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (sched.size() > 0) begin
                w       = sched.pop_front();
                m_valid = 1'b1;
                m_last  = w[W];
                m_data  = w[W-1:0];
            end else begin
                m_valid = 1'b0;
                m_last  = 1'b0;
            end
        end
        m_busy = m_valid || (sched.size() >= N);
    endtask

    // One clock cycle: model follows the edge, new inputs are applied just
    // after it, and outputs are compared against the model mid-cycle.
    task automatic step(input logic r, input logic v, input logic [FW-1:0] d);
        @(posedge clk);
        model_edge();
        #1;
        rst      = r;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        chk("out_last",  {63'd0, out_last},  {63'd0, m_last});
        chk("out_data",  {48'd0, out_data},  {48'd0, m_data});
        chk("busy",      {63'd0, busy},      {63'd0, m_busy});
        chk("overrun",   {63'd0, overrun},   {63'd0, m_ovr});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    logic [FW-1:0] fa, fb, fc, fr;

    initial begin
        fa = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        fb = {16'h00B4, 16'h00B3, 16'h00B2, 16'h00B1};
        fc = {16'h00C4, 16'h00C3, 16'h00C2, 16'h00C1};

        // Reset state
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data",  {48'd0, out_data},  64'd0);
        chk("rst_busy",  {63'd0, busy},      64'd0);
        chk("rst_ovr",   {63'd0, overrun},   64'd0);

        // Single frame: words 1..4 in T+1..T+4, idle at T+5
        step(1'b0, 1'b1, fa);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, '0);
            if (k <= 4) begin
                chk("single_valid", {63'd0, out_valid}, 64'd1);
                chk("single_data",  {48'd0, out_data},  64'(k));
                chk("single_last",  {63'd0, out_last},  (k == 4) ? 64'd1 : 64'd0);
            end else begin
                chk("single_idle_valid", {63'd0, out_valid}, 64'd0);
                chk("single_idle_busy",  {63'd0, busy},      64'd0);
                chk("single_hold_data",  {48'd0, out_data},  64'd4);
            end
        end
        idle(3);

        // A at T, B at T+2: B in T+5..T+8, no overrun
        step(1'b0, 1'b1, fa);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, fb);
        for (int k = 3; k <= 9; k++) begin
            step(1'b0, 1'b0, '0);
            if (k == 5) chk("ab_b_first", {48'd0, out_data}, 64'h00B1);
            if (k == 8) chk("ab_b_last",  {62'd0, out_last, out_valid}, 64'd3);
            if (k == 9) chk("ab_idle",    {63'd0, out_valid}, 64'd0);
            if (k == 9) chk("ab_ovr",     {63'd0, overrun},   64'd0);
        end
        idle(3);

        // A at T, B at T+1, C at T+2: C dropped, overrun from T+3
        step(1'b0, 1'b1, fa);
        step(1'b0, 1'b1, fb);
        step(1'b0, 1'b1, fc);
        for (int k = 3; k <= 9; k++) begin
            step(1'b0, 1'b0, '0);
            if (k == 3) chk("abc_ovr_set", {63'd0, overrun},  64'd1);
            if (k == 5) chk("abc_b_first", {48'd0, out_data}, 64'h00B1);
            if (k == 9) chk("abc_c_drop",  {63'd0, out_valid}, 64'd0);
        end
        idle(2);

        // Reset mid-frame at T+2 (overrun still set from above)
        step(1'b0, 1'b1, fa);
        step(1'b0, 1'b1, fb);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("rstmid_valid", {63'd0, out_valid}, 64'd0);
        chk("rstmid_busy",  {63'd0, busy},      64'd0);
        chk("rstmid_ovr",   {63'd0, overrun},   64'd0);
        idle(2);
        chk("rstmid_no_pend", {63'd0, out_valid}, 64'd0);
        step(1'b0, 1'b1, fc);
        step(1'b0, 1'b0, '0);
        chk("rstmid_fresh", {48'd0, out_data}, 64'h00C1);
        idle(5);

        // A at T, B at T+1, C at T+4: back-to-back over T+1..T+12
        step(1'b0, 1'b1, fa);
        step(1'b0, 1'b1, fb);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, fc);
        for (int k = 5; k <= 13; k++) begin
            step(1'b0, 1'b0, '0);
            if (k <= 12) chk("abc4_valid", {63'd0, out_valid}, 64'd1);
            if (k == 9)  chk("abc4_c_first", {48'd0, out_data}, 64'h00C1);
            if (k == 12) chk("abc4_c_last",  {47'd0, out_last, out_data}, {47'd0, 1'b1, 16'h00C4});
            if (k == 12) chk("abc4_ovr",     {63'd0, overrun}, 64'd0);
            if (k == 13) chk("abc4_idle",    {63'd0, out_valid}, 64'd0);
        end
        idle(3);

        // Randomized traffic with occasional resets, checked against the model
        for (int i = 0; i < 3000; i++) begin
            fr = {$urandom(), $urandom()};
            step(($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 6)),
                 fr);
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
